// File: rtl/ace_pkg.sv
// ace_pkg: shared types and constants for the ACE snoop collector.
//   state_t     - collector sequencing states
//   CR_*        - bit positions inside a CRRESP[4:0] field
//   SNOOP_*     - ACSNOOP codes used by requesters
package ace_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AC   = 3'd1,
        CR   = 3'd2,
        CD   = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam int CR_DATA_TRANSFER = 0;
    localparam int CR_ERROR         = 1;
    localparam int CR_PASS_DIRTY    = 2;
    localparam int CR_IS_SHARED     = 3;
    localparam int CR_WAS_UNIQUE    = 4;

    localparam logic [3:0] SNOOP_READ_SHARED   = 4'b0001;
    localparam logic [3:0] SNOOP_READ_UNIQUE   = 4'b0111;
    localparam logic [3:0] SNOOP_CLEAN_INVALID = 4'b1001;

endpackage

// File: rtl/snoop_prio_sel.sv
// snoop_prio_sel: lowest-index priority select.
//   valid [N-1:0] in  - candidate mask
//   sel   [N-1:0] out - one-hot of the lowest set bit of valid (0 if none)
//   found         out - valid has at least one bit set
module snoop_prio_sel #(
    parameter int N = 8
) (
    input  logic [N-1:0] valid,
    output logic [N-1:0] sel,
    output logic         found
);

    // Two's complement isolates the lowest set bit.
    assign sel   = valid & (~valid + {{(N-1){1'b0}}, 1'b1});
    assign found = |valid;

endmodule

// File: rtl/ace_snoop_collector.sv
// ace_snoop_collector: home-side snoop sequencer.
// Accepts one coherent request, broadcasts it on AC to every master except
// the initiator, collects CR responses, drains CD data from masters that
// signalled DataTransfer and returns one merged response.
//   ACLK, ARESETn            clock, asynchronous active-low reset
//   req_*                    request from initiator (valid/ready)
//   ac_*                     per-master snoop address channel
//   cr_*                     per-master snoop response channel (5 bits each)
//   cd_*                     per-master snoop data channel (one beat per line)
//   rsp_*                    merged response (valid/ready)
module ace_snoop_collector
    import ace_pkg::*;
#(
    parameter int DATA_SIZE   = 128,
    parameter int NUM_MASTERS = 8,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESETn,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [ADDR_WIDTH-1:0]           req_addr,
    input  logic [3:0]                      req_snoop,
    input  logic [NUM_MASTERS-1:0]          req_src,
    output logic [NUM_MASTERS-1:0]          ac_valid,
    input  logic [NUM_MASTERS-1:0]          ac_ready,
    output logic [ADDR_WIDTH-1:0]           ac_addr,
    output logic [3:0]                      ac_snoop,
    input  logic [NUM_MASTERS-1:0]          cr_valid,
    output logic [NUM_MASTERS-1:0]          cr_ready,
    input  logic [5*NUM_MASTERS-1:0]        cr_resp,
    input  logic [NUM_MASTERS-1:0]          cd_valid,
    output logic [NUM_MASTERS-1:0]          cd_ready,
    input  logic [DATA_SIZE*NUM_MASTERS-1:0] cd_data,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_hit,
    output logic [NUM_MASTERS-1:0]          rsp_sel,
    output logic [DATA_SIZE-1:0]            rsp_data,
    output logic                            rsp_shared,
    output logic                            rsp_dirty,
    output logic                            rsp_err
);

    state_t                   state_q, state_d;
    logic [NUM_MASTERS-1:0]   ac_pend_q, ac_pend_d;
    logic [NUM_MASTERS-1:0]   cr_pend_q, cr_pend_d;
    logic [NUM_MASTERS-1:0]   cd_pend_q, cd_pend_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [3:0]               snoop_q, snoop_d;
    logic                     shared_q, shared_d;
    logic                     dirty_q, dirty_d;
    logic                     err_q, err_d;
    logic [NUM_MASTERS-1:0]   sel_q, sel_d;
    logic [DATA_SIZE-1:0]     data_q, data_d;

    logic [NUM_MASTERS-1:0]   ac_hs, cr_hs, cd_hs, cr_dt;
    logic [NUM_MASTERS-1:0]   cd_first;
    logic                     cd_found;
    logic [DATA_SIZE-1:0]     cd_first_data;
    logic                     in_resp;

    assign ac_valid  = (state_q == AC) ? ac_pend_q : '0;
    assign cr_ready  = (state_q == CR) ? cr_pend_q : '0;
    assign cd_ready  = (state_q == CD) ? cd_pend_q : '0;
    assign ac_hs     = ac_valid & ac_ready;
    assign cr_hs     = cr_ready & cr_valid;
    assign cd_hs     = cd_ready & cd_valid;
    assign ac_addr   = addr_q;
    assign ac_snoop  = snoop_q;
    assign req_ready = (state_q == IDLE);

    // Response fields are built up during CR/CD; expose them only in RESP.
    assign in_resp    = (state_q == RESP);
    assign rsp_valid  = in_resp;
    assign rsp_sel    = in_resp ? sel_q : '0;
    assign rsp_data   = in_resp ? data_q : '0;
    assign rsp_hit    = in_resp & (|sel_q);
    assign rsp_shared = in_resp & shared_q;
    assign rsp_dirty  = in_resp & dirty_q;
    assign rsp_err    = in_resp & err_q;

    snoop_prio_sel #(.N(NUM_MASTERS)) u_cd_sel (
        .valid (cd_hs),
        .sel   (cd_first),
        .found (cd_found)
    );

    // NOTE: combinational logic uses blocking '=' with every output given a
    // default first, so no latch is inferred; state registers use '<='.
    always_comb begin
        cd_first_data = '0;
        cr_dt         = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (cd_first[i]) cd_first_data = cd_first_data | cd_data[i*DATA_SIZE +: DATA_SIZE];
            cr_dt[i] = cr_resp[5*i + CR_DATA_TRANSFER];
        end
    end

    always_comb begin
        state_d   = state_q;
        ac_pend_d = ac_pend_q;
        cr_pend_d = cr_pend_q;
        cd_pend_d = cd_pend_q;
        addr_d    = addr_q;
        snoop_d   = snoop_q;
        shared_d  = shared_q;
        dirty_d   = dirty_q;
        err_d     = err_q;
        sel_d     = sel_q;
        data_d    = data_q;
        unique case (state_q)
            IDLE: if (req_valid) begin
                addr_d    = req_addr;
                snoop_d   = req_snoop;
                ac_pend_d = ~req_src;
                cr_pend_d = '0;
                cd_pend_d = '0;
                shared_d  = 1'b0;
                dirty_d   = 1'b0;
                err_d     = 1'b0;
                sel_d     = '0;
                data_d    = '0;
                state_d   = (~req_src == '0) ? RESP : AC;
            end
            AC: begin
                ac_pend_d = ac_pend_q & ~ac_hs;
                cr_pend_d = cr_pend_q | ac_hs;
                if (ac_pend_d == '0) state_d = CR;
            end
            CR: begin
                cr_pend_d = cr_pend_q & ~cr_hs;
                cd_pend_d = cd_pend_q | (cr_hs & cr_dt);
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (cr_hs[i]) begin
                        err_d    = err_d    | cr_resp[5*i + CR_ERROR];
                        dirty_d  = dirty_d  | cr_resp[5*i + CR_PASS_DIRTY];
                        shared_d = shared_d | cr_resp[5*i + CR_IS_SHARED];
                    end
                end
                if (cr_pend_d == '0) state_d = (cd_pend_d != '0) ? CD : RESP;
            end
            CD: begin
                cd_pend_d = cd_pend_q & ~cd_hs;
                // Only the first line to arrive is kept; later beats are drained.
                if (sel_q == '0 && cd_found) begin
                    sel_d  = cd_first;
                    data_d = cd_first_data;
                end
                if (cd_pend_d == '0) state_d = RESP;
            end
            RESP: if (rsp_ready) begin
                state_d  = IDLE;
                shared_d = 1'b0;
                dirty_d  = 1'b0;
                err_d    = 1'b0;
                sel_d    = '0;
                data_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the captured line is a plain register, not a memory, so it is
    // reset along with the control state; reset mid-transaction drops it.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            ac_pend_q <= '0;
            cr_pend_q <= '0;
            cd_pend_q <= '0;
            addr_q    <= '0;
            snoop_q   <= '0;
            shared_q  <= 1'b0;
            dirty_q   <= 1'b0;
            err_q     <= 1'b0;
            sel_q     <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            ac_pend_q <= ac_pend_d;
            cr_pend_q <= cr_pend_d;
            cd_pend_q <= cd_pend_d;
            addr_q    <= addr_d;
            snoop_q   <= snoop_d;
            shared_q  <= shared_d;
            dirty_q   <= dirty_d;
            err_q     <= err_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
        end
    end

endmodule

// File: tb/tb_ace_snoop_collector.sv
// Testbench for ace_snoop_collector: directed transactions with a scoreboard
// of hand-computed merged responses and a behavioural model of the masters.
module tb_ace_snoop_collector;
    import ace_pkg::*;

    localparam int DS = 128;
    localparam int NM = 8;
    localparam int AW = 32;

    logic              ACLK = 1'b0;
    logic              ARESETn;
    logic              req_valid, req_ready;
    logic [AW-1:0]     req_addr;
    logic [3:0]        req_snoop;
    logic [NM-1:0]     req_src;
    logic [NM-1:0]     ac_valid, ac_ready;
    logic [AW-1:0]     ac_addr;
    logic [3:0]        ac_snoop;
    logic [NM-1:0]     cr_valid, cr_ready;
    logic [5*NM-1:0]   cr_resp;
    logic [NM-1:0]     cd_valid, cd_ready;
    logic [DS*NM-1:0]  cd_data;
    logic              rsp_valid, rsp_ready;
    logic              rsp_hit, rsp_shared, rsp_dirty, rsp_err;
    logic [NM-1:0]     rsp_sel;
    logic [DS-1:0]     rsp_data;

    ace_snoop_collector #(.DATA_SIZE(DS), .NUM_MASTERS(NM), .ADDR_WIDTH(AW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_snoop(req_snoop), .req_src(req_src),
        .ac_valid(ac_valid), .ac_ready(ac_ready), .ac_addr(ac_addr), .ac_snoop(ac_snoop),
        .cr_valid(cr_valid), .cr_ready(cr_ready), .cr_resp(cr_resp),
        .cd_valid(cd_valid), .cd_ready(cd_ready), .cd_data(cd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_sel(rsp_sel), .rsp_data(rsp_data), .rsp_shared(rsp_shared),
        .rsp_dirty(rsp_dirty), .rsp_err(rsp_err)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic          hit;
        logic [NM-1:0] sel;
        logic [DS-1:0] data;
        logic          shared;
        logic          dirty;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Per-master behaviour, set by the test sequence.
    logic [4:0]    cr_cfg [NM];
    logic [DS-1:0] cd_cfg [NM];
    logic          cd_en;
    logic [NM-1:0] stall_mask;
    int            stall_cnt;

    logic [NM-1:0] m_cr, m_cd, hs_ac, hs_cr, hs_cd;

    task automatic check(input string name, input logic [DS-1:0] act, input logic [DS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Master model: responds to AC with CR the next cycle, and to CR with
    // DataTransfer by offering CD the next cycle. Handshakes are recorded
    // just after inputs are driven and take effect at the following negedge.
    initial begin
        m_cr = '0; m_cd = '0; hs_ac = '0; hs_cr = '0; hs_cd = '0;
        ac_ready = '1; cr_valid = '0; cd_valid = '0; cr_resp = '0; cd_data = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                m_cr = '0;
                m_cd = '0;
            end else begin
                m_cr = (m_cr | hs_ac) & ~hs_cr;
                m_cd = (m_cd | (hs_cr & cr_dt_mask())) & ~hs_cd;
            end
            if (stall_cnt > 0 && (ac_valid & stall_mask) != '0) stall_cnt--;
            ac_ready = (stall_cnt > 0) ? ~stall_mask : '1;
            for (int i = 0; i < NM; i++) begin
                cr_resp[5*i +: 5]  = cr_cfg[i];
                cd_data[DS*i +: DS] = cd_cfg[i];
            end
            cr_valid = m_cr;
            cd_valid = cd_en ? m_cd : '0;
            #1;
            hs_ac = ac_valid & ac_ready;
            hs_cr = cr_valid & cr_ready;
            hs_cd = cd_valid & cd_ready;
        end
    end

    function automatic logic [NM-1:0] cr_dt_mask();
        logic [NM-1:0] m;
        for (int i = 0; i < NM; i++) m[i] = cr_cfg[i][CR_DATA_TRANSFER];
        return m;
    endfunction

    // Scoreboard monitor: compares every accepted response against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge ACLK);
            #2;
            if (ARESETn && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got sel %0h with no expected response", rsp_sel);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_hit",    DS'(rsp_hit),    DS'(e.hit));
                    check("rsp_sel",    DS'(rsp_sel),    DS'(e.sel));
                    check("rsp_data",   rsp_data,        e.data);
                    check("rsp_shared", DS'(rsp_shared), DS'(e.shared));
                    check("rsp_dirty",  DS'(rsp_dirty),  DS'(e.dirty));
                    check("rsp_err",    DS'(rsp_err),    DS'(e.err));
                end
            end
        end
    end

    task automatic clear_cfg();
        for (int i = 0; i < NM; i++) begin
            cr_cfg[i] = 5'b00000;
            cd_cfg[i] = '0;
        end
    endtask

    // Drives one request; returns at the negedge after acceptance (cycle 1).
    task automatic start_req(input logic [AW-1:0] a, input logic [3:0] s, input logic [NM-1:0] src);
        int n = 0;
        @(negedge ACLK);
        while (!req_ready && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        check("req_ready_before_req", DS'(req_ready), DS'(1'b1));
        req_addr = a; req_snoop = s; req_src = src; req_valid = 1'b1;
        @(negedge ACLK);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(negedge ACLK);
            lat++;
        end
        check("rsp_valid_seen", DS'(rsp_valid), DS'(1'b1));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        check("returned_idle", DS'(exp_q.size() == 0 && req_ready), DS'(1'b1));
    endtask

    localparam logic [DS-1:0] LINE_A5 = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
    localparam logic [DS-1:0] LINE_2  = 128'h22222222_22222222_22222222_22222222;
    localparam logic [DS-1:0] LINE_5  = 128'h55555555_55555555_55555555_55555555;
    localparam logic [DS-1:0] LINE_DB = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

    initial begin
        int   lat;
        int   n;
        exp_t e;
        exp_t snap;
        ARESETn = 1'b0; req_valid = 1'b0; req_addr = '0; req_snoop = '0; req_src = '0;
        rsp_ready = 1'b1; cd_en = 1'b1; stall_mask = '0; stall_cnt = 0;
        clear_cfg();
        repeat (3) @(negedge ACLK);
        check("reset_req_ready", DS'(req_ready), DS'(1'b1));
        check("reset_ac_valid",  DS'(ac_valid),  '0);
        check("reset_rsp_valid", DS'(rsp_valid), '0);
        check("reset_rsp_data",  rsp_data,       '0);
        ARESETn = 1'b1;

        // 1: no master has data -> response in cycle 3, all zero.
        clear_cfg();
        e = '{hit: 1'b0, sel: 8'h00, data: '0, shared: 1'b0, dirty: 1'b0, err: 1'b0};
        exp_q.push_back(e);
        start_req(32'h0000_1000, SNOOP_READ_SHARED, 8'h01);
        wait_rsp(lat);
        check("latency_no_data", DS'(lat), DS'(3));
        check("ac_addr_latched", DS'(ac_addr), DS'(32'h0000_1000));
        wait_idle();

        // 2: master 3 supplies a shared line -> response in cycle 4.
        clear_cfg();
        cr_cfg[3] = 5'b01001; cd_cfg[3] = LINE_A5;
        e = '{hit: 1'b1, sel: 8'h08, data: LINE_A5, shared: 1'b1, dirty: 1'b0, err: 1'b0};
        exp_q.push_back(e);
        start_req(32'h0000_2040, SNOOP_READ_SHARED, 8'h01);
        wait_rsp(lat);
        check("latency_data", DS'(lat), DS'(4));
        wait_idle();

        // 3: masters 2 and 5 return data in the same cycle -> master 2 wins.
        clear_cfg();
        cr_cfg[2] = 5'b00001; cd_cfg[2] = LINE_2;
        cr_cfg[5] = 5'b00001; cd_cfg[5] = LINE_5;
        e = '{hit: 1'b1, sel: 8'h04, data: LINE_2, shared: 1'b0, dirty: 1'b0, err: 1'b0};
        exp_q.push_back(e);
        start_req(32'h0000_3080, SNOOP_READ_UNIQUE, 8'h01);
        n = 0;
        while (cd_ready == '0 && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        check("cd_ready_both", DS'(cd_ready), DS'(8'h24));
        wait_idle();

        // 4: master 6 stalls AC for 10 cycles.
        clear_cfg();
        cr_cfg[6] = 5'b10000;
        stall_mask = 8'h40; stall_cnt = 10;
        e = '{hit: 1'b0, sel: 8'h00, data: '0, shared: 1'b0, dirty: 1'b0, err: 1'b0};
        exp_q.push_back(e);
        start_req(32'hCAFE_0000, SNOOP_CLEAN_INVALID, 8'h01);
        repeat (2) @(negedge ACLK);
        for (int k = 0; k < 6; k++) begin
            check("stall_ac_valid6", DS'(ac_valid[6]), DS'(1'b1));
            check("stall_ac_addr",   DS'(ac_addr),     DS'(32'hCAFE_0000));
            check("stall_ac_snoop",  DS'(ac_snoop),    DS'(SNOOP_CLEAN_INVALID));
            check("stall_no_cr",     DS'(cr_ready),    '0);
            @(negedge ACLK);
        end
        wait_idle();
        stall_mask = '0;

        // 5: master 4 reports Error and PassDirty without data.
        clear_cfg();
        cr_cfg[4] = 5'b00110;
        e = '{hit: 1'b0, sel: 8'h00, data: '0, shared: 1'b0, dirty: 1'b1, err: 1'b1};
        exp_q.push_back(e);
        start_req(32'h0000_4000, SNOOP_READ_SHARED, 8'h01);
        wait_idle();

        // 6: reset while waiting on CD abandons the transaction.
        clear_cfg();
        cr_cfg[3] = 5'b00001; cd_cfg[3] = LINE_A5;
        cd_en = 1'b0;
        start_req(32'h0000_5000, SNOOP_READ_SHARED, 8'h01);
        n = 0;
        while (cd_ready == '0 && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        check("in_cd_before_reset", DS'(cd_ready), DS'(8'h08));
        ARESETn = 1'b0;
        #2;
        check("midreset_cd_ready",  DS'(cd_ready),  '0);
        check("midreset_req_ready", DS'(req_ready), DS'(1'b1));
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        cd_en = 1'b1;
        @(negedge ACLK);
        check("postreset_req_ready", DS'(req_ready), DS'(1'b1));
        check("postreset_rsp_valid", DS'(rsp_valid), '0);
        check("postreset_rsp_sel",   DS'(rsp_sel),   '0);
        e = '{hit: 1'b1, sel: 8'h08, data: LINE_A5, shared: 1'b0, dirty: 1'b0, err: 1'b0};
        exp_q.push_back(e);
        start_req(32'h0000_5000, SNOOP_READ_SHARED, 8'h01);
        wait_idle();

        // 7: consumer back-pressure holds the response stable.
        clear_cfg();
        cr_cfg[0] = 5'b00101; cd_cfg[0] = LINE_DB;
        rsp_ready = 1'b0;
        e = '{hit: 1'b1, sel: 8'h01, data: LINE_DB, shared: 1'b0, dirty: 1'b1, err: 1'b0};
        exp_q.push_back(e);
        start_req(32'h0000_6000, SNOOP_READ_UNIQUE, 8'h02);
        wait_rsp(lat);
        snap = '{hit: rsp_hit, sel: rsp_sel, data: rsp_data, shared: rsp_shared,
                 dirty: rsp_dirty, err: rsp_err};
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            check("bp_rsp_valid", DS'(rsp_valid), DS'(1'b1));
            check("bp_req_ready", DS'(req_ready), '0);
            check("bp_rsp_data",  rsp_data, snap.data);
            check("bp_rsp_sel",   DS'(rsp_sel), DS'(snap.sel));
        end
        rsp_ready = 1'b1;
        wait_idle();
        @(negedge ACLK);
        check("final_rsp_valid", DS'(rsp_valid), '0);
        check("final_rsp_data",  rsp_data, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
